// File: rtl/ex_result_stage.sv
// ex_result_stage: execute-to-memory boundary register.
// Registers each ALU result with its rewrite (overflow -> rstatus write),
// resolves bne/blt into a one-cycle redirect pulse, and hands entries to the
// memory stage over a valid/ready link.
// Build option: define STAGE_SKID_EN for a two-slot skid buffer with a
// registered in_ready; otherwise a single slot with a combinational in_ready.
//
// Handshake: an entry moves on a side when that side's valid and ready are both
// high at a rising clock edge; a presented output (out_valid=1) holds all out_*
// values until out_ready or flush retires it.
module ex_result_stage #(
    parameter int PC_W        = 32,
    parameter int RSTATUS_REG = 30
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_kind,
    input  logic [4:0]      in_aluop,
    input  logic [31:0]     in_result,
    input  logic            in_overflow,
    input  logic            in_ne,
    input  logic            in_lt,
    input  logic [4:0]      in_rd,
    input  logic [PC_W-1:0] in_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_exc,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_target
);

    localparam logic [4:0] RSTATUS_RD = 5'(RSTATUS_REG);

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
    } entry_t;

    entry_t          entry_d;
    logic            taken_d;
    logic            accept;
    logic            pop;
    entry_t          head_q;
    logic            out_valid_q;
    logic            redirect_valid_q;
    logic [PC_W-1:0] redirect_target_q;

    // Decode the incoming entry: write enable, overflow rewrite, branch outcome.
    always_comb begin
        entry_d.result = in_result;
        entry_d.rd     = in_rd;
        entry_d.we     = 1'b0;
        entry_d.exc    = 1'b0;
        taken_d        = 1'b0;
        case (in_kind)
            3'd0: begin
                entry_d.we = 1'b1;
                if (in_overflow && in_aluop == 5'b00000) begin
                    entry_d.result = 32'd1;
                    entry_d.rd     = RSTATUS_RD;
                    entry_d.exc    = 1'b1;
                end else if (in_overflow && in_aluop == 5'b00001) begin
                    entry_d.result = 32'd3;
                    entry_d.rd     = RSTATUS_RD;
                    entry_d.exc    = 1'b1;
                end
            end
            3'd1: begin
                entry_d.we = 1'b1;
                if (in_overflow) begin
                    entry_d.result = 32'd2;
                    entry_d.rd     = RSTATUS_RD;
                    entry_d.exc    = 1'b1;
                end
            end
            3'd2: taken_d = in_ne;
            3'd3: taken_d = in_lt;
            3'd4: entry_d.we = 1'b1;
            default: ;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign pop    = out_valid_q & out_ready;

    // Redirect pulse for the cycle after a taken branch is accepted; target sticks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            redirect_valid_q  <= 1'b0;
            redirect_target_q <= '0;
        end else begin
            redirect_valid_q <= accept & taken_d & ~flush;
            if (accept & taken_d & ~flush) begin
                redirect_target_q <= in_target;
            end
        end
    end

`ifdef STAGE_SKID_EN
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t state_q;
    entry_t slot1_q;
    logic   in_ready_q;

    // Two-slot FIFO: head_q is presented, slot1_q holds the skid entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            head_q      <= '0;
            slot1_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        head_q      <= entry_d;
                        state_q     <= S_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && !pop) begin
                        slot1_q    <= entry_d;
                        state_q    <= S_FULL;
                        in_ready_q <= 1'b0;
                    end else if (!accept && pop) begin
                        state_q     <= S_EMPTY;
                        out_valid_q <= 1'b0;
                    end else if (accept && pop) begin
                        head_q <= entry_d;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        head_q     <= slot1_q;
                        state_q    <= S_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
`else
    typedef enum logic {S_EMPTY, S_ONE} state_t;

    state_t state_q;

    // Single slot: refill in the same cycle the held entry leaves.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            head_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        head_q      <= entry_d;
                        state_q     <= S_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        head_q <= entry_d;
                    end else if (pop) begin
                        state_q     <= S_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign in_ready = ~out_valid_q | out_ready;
`endif

    assign out_valid       = out_valid_q;
    assign out_result      = head_q.result;
    assign out_rd          = head_q.rd;
    assign out_we          = head_q.we;
    assign out_exc         = head_q.exc;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_target = redirect_target_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Bench for ex_result_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_ex_result_stage;

    localparam int PC_W = 32;
`ifdef STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_kind = 3'd7;
    logic [4:0]      in_aluop = 5'd0;
    logic [31:0]     in_result = 32'd0;
    logic            in_overflow = 1'b0;
    logic            in_ne = 1'b0;
    logic            in_lt = 1'b0;
    logic [4:0]      in_rd = 5'd0;
    logic [PC_W-1:0] in_target = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_result;
    logic [4:0]      out_rd;
    logic            out_we;
    logic            out_exc;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_target;

    ex_result_stage #(.PC_W(PC_W), .RSTATUS_REG(30)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_aluop(in_aluop), .in_result(in_result),
        .in_overflow(in_overflow), .in_ne(in_ne), .in_lt(in_lt),
        .in_rd(in_rd), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_we(out_we), .out_exc(out_exc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
    } ent_t;

    ent_t            exp_q[$];
    logic            exp_redir = 1'b0;
    logic [PC_W-1:0] exp_target = '0;
    int              tests = 0;
    int              fails = 0;
    bit              check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // What the memory stage must receive for one upstream entry.
    function automatic ent_t model_entry(input logic [2:0] kind, input logic [4:0] op,
                                         input logic [31:0] res, input logic ovf,
                                         input logic [4:0] rd);
        ent_t e;
        e.result = res;
        e.rd     = rd;
        e.exc    = 1'b0;
        e.we     = (kind == 3'd0) || (kind == 3'd1) || (kind == 3'd4);
        if (ovf && ((kind == 3'd0 && (op == 5'd0 || op == 5'd1)) || kind == 3'd1)) begin
            e.exc    = 1'b1;
            e.rd     = 5'd30;
            e.result = (kind == 3'd1) ? 32'd2 : ((op == 5'd0) ? 32'd1 : 32'd3);
        end
        return e;
    endfunction

    function automatic bit model_taken(input logic [2:0] kind, input logic ne, input logic lt);
        return (kind == 3'd2 && ne) || (kind == 3'd3 && lt);
    endfunction

    // Room for one more entry: free capacity, or (single slot) the head leaving now.
    function automatic bit model_ready();
        return (exp_q.size() < CAP) || (CAP == 1 && out_ready);
    endfunction

    // Reference model advances on each clock edge from the sampled inputs.
    always @(posedge clock or posedge reset) begin : model
        bit pop;
        bit acc;
        if (reset) begin
            exp_q.delete();
            exp_redir  = 1'b0;
            exp_target = '0;
        end else begin
            pop = (exp_q.size() > 0) && out_ready;
            acc = in_valid && model_ready();
            if (flush) begin
                exp_q.delete();
                exp_redir = 1'b0;
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(model_entry(in_kind, in_aluop, in_result, in_overflow, in_rd));
                exp_redir = acc && model_taken(in_kind, in_ne, in_lt);
                if (exp_redir) exp_target = in_target;
            end
        end
    end

    // Per-cycle comparison, mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (check_en) begin
            check("in_ready", in_ready, model_ready());
            check("out_valid", out_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("out_result", out_result, exp_q[0].result);
                check("out_rd", out_rd, exp_q[0].rd);
                check("out_we", out_we, exp_q[0].we);
                check("out_exc", out_exc, exp_q[0].exc);
            end
            check("redirect_valid", redirect_valid, exp_redir);
            check("redirect_target", redirect_target, exp_target);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic offer(input logic [2:0] kind, input logic [4:0] op, input logic [31:0] res,
                         input logic ovf, input logic ne, input logic lt,
                         input logic [4:0] rd, input logic [PC_W-1:0] tgt);
        in_valid    = 1'b1;
        in_kind     = kind;
        in_aluop    = op;
        in_result   = res;
        in_overflow = ovf;
        in_ne       = ne;
        in_lt       = lt;
        in_rd       = rd;
        in_target   = tgt;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_kind  = 3'd7;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_redirect", redirect_valid, 1'b0);
        check("rst_out_fields", {out_result, out_rd, out_we, out_exc}, '0);
        check("rst_target", redirect_target, '0);
        step();
        reset = 1'b0;
        check_en = 1'b1;
        out_ready = 1'b1;
        step();

        // 1: add overflow rewritten to rstatus=1
        offer(3'd0, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 5'd5, '0);
        step();
        check("t1_result", out_result, 32'd1);
        check("t1_rd", out_rd, 5'd30);
        check("t1_we_exc", {out_we, out_exc}, 2'b11);

        // 2: addi overflow then sub overflow, in order
        offer(3'd1, 5'd0, 32'h1234, 1'b1, 1'b0, 1'b0, 5'd7, '0);
        step();
        check("t2_addi_result", out_result, 32'd2);
        offer(3'd0, 5'd1, 32'h5678, 1'b1, 1'b0, 1'b0, 5'd8, '0);
        step();
        check("t2_sub_result", out_result, 32'd3);
        check("t2_sub_rd_exc", {out_rd, out_exc}, {5'd30, 1'b1});

        // 3: taken BLT gives a one-cycle pulse; untaken BNE gives none
        offer(3'd3, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h40);
        step();
        idle();
        check("t3_pulse", redirect_valid, 1'b1);
        check("t3_target", redirect_target, 32'h40);
        check("t3_we", out_we, 1'b0);
        step();
        check("t3_pulse_end", redirect_valid, 1'b0);
        offer(3'd2, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h80);
        step();
        idle();
        check("t3_bne_nopulse", redirect_valid, 1'b0);
        check("t3_target_hold", redirect_target, 32'h40);
        step();

        // 4: stall, offer three entries, then drain
        out_ready = 1'b0;
        offer(3'd4, 5'd0, 32'hA1, 1'b0, 1'b0, 1'b0, 5'd1, '0);
        step();
        offer(3'd4, 5'd0, 32'hB2, 1'b0, 1'b0, 1'b0, 5'd2, '0);
        step();
        offer(3'd4, 5'd0, 32'hC3, 1'b0, 1'b0, 1'b0, 5'd3, '0);
        step();
        step();
        check("t4_in_ready_stalled", in_ready, 1'b0);
        check("t4_head_stable", out_result, 32'hA1);
        idle();
        out_ready = 1'b1;
        step();
`ifdef STAGE_SKID_EN
        check("t4_second_entry", out_result, 32'hB2);
`else
        check("t4_drained", out_valid, 1'b0);
`endif
        step();
        step();

        // 5: full buffer + flush with a taken BNE offered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(3'd4, 5'd0, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0, 5'(i + 4), '0);
            step();
        end
        offer(3'd2, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h100);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_no_redirect", redirect_valid, 1'b0);
        check("t5_in_ready", in_ready, 1'b1);
        offer(3'd2, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h200);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("t5_empty_flush_nopulse", redirect_valid, 1'b0);
        check("t5_target_hold", redirect_target, 32'h40);

        // 6: reset mid-stall with a redirect pulse in flight
        if (CAP > 1) begin
            offer(3'd4, 5'd0, 32'hDD, 1'b0, 1'b0, 1'b0, 5'd9, '0);
            step();
        end
        offer(3'd3, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h300);
        step();
        idle();
        check("t6_pulse_before_reset", redirect_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_redirect", redirect_valid, 1'b0);
        check("t6_fields", {out_result, out_rd, out_we, out_exc}, '0);
        check("t6_target", redirect_target, '0);
        step();
        step();
        reset = 1'b0;
        step();
        check("t6_no_redirect_after", redirect_valid, 1'b0);
        check("t6_empty_after", out_valid, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_kind     = 3'($urandom_range(0, 7));
            in_aluop    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 1));
            in_result   = $urandom;
            in_overflow = $urandom_range(0, 1) == 1;
            in_ne       = $urandom_range(0, 1) == 1;
            in_lt       = $urandom_range(0, 1) == 1;
            in_rd       = 5'($urandom_range(0, 31));
            in_target   = PC_W'($urandom);
            out_ready   = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 15) == 0);
            step();
        end
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
